// File: rtl/cordic_log_seq_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cordic_log_seq_if
// Handshake bundle between the input validation stage, the CORDIC log
// sequencer and the output stage.
//   in_valid / in_exponent / in_ready / in_drop : operand side
//   out_valid / out_ready / out_exp / out_err    : result side
// master : the environment (drives the operand and out_ready)
// slave  : the sequencer (drives ready/drop and the result)
// -----------------------------------------------------------------------------
interface cordic_log_seq_if;
    logic       in_valid;
    logic [7:0] in_exponent;
    logic       in_ready;
    logic       in_drop;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_exp;
    logic       out_err;

    modport master (
        output in_valid, in_exponent, out_ready,
        input  in_ready, in_drop, out_valid, out_exp, out_err
    );

    modport slave (
        input  in_valid, in_exponent, out_ready,
        output in_ready, in_drop, out_valid, out_exp, out_err
    );
endinterface

// File: rtl/cordic_log_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cordic_log_seq
// Control sequencer for the iterative hyperbolic CORDIC logarithm engine.
// Accepts one biased exponent per transaction, steps the shared datapath
// through load, micro-rotation and final-combine phases, and returns the
// unbiased exponent with a valid/ready handshake.  The hyperbolic shift
// schedule repeats k = 4 and k = 13 once each (when within ITER) so the
// iteration converges.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   bus         : operand/result handshake (slave side)
//   ld_o        : load x/y/z datapath registers
//   it_en_o     : perform one micro-rotation this cycle
//   shift_o     : shift amount k of the current micro-rotation
//   lut_addr_o  : atanh(2^-k) ROM address (k-1)
//   fin_o       : final combine ln = 2z + e*ln2
// -----------------------------------------------------------------------------
module cordic_log_seq #(
    parameter int ITER = 16
) (
    input  logic             clk,
    input  logic             reset,
    cordic_log_seq_if.slave  bus,
    output logic             ld_o,
    output logic             it_en_o,
    output logic [4:0]       shift_o,
    output logic [4:0]       lut_addr_o,
    output logic             fin_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ITER = 3'd2,
        S_FIN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [4:0] ITER_K = 5'(ITER);

    // Exponents 0x00 (zero/subnormal) and 0xFF (inf/NaN) have no finite log.
    function automatic logic is_reserved(input logic [7:0] e);
        return (e == 8'h00) || (e == 8'hFF);
    endfunction

    // Two's-complement unbiased exponent.
    function automatic logic [8:0] unbias(input logic [7:0] e);
        return {1'b0, e} - 9'd127;
    endfunction

    state_t     state_q;
    logic [4:0] k_q;
    logic       rep_q;
    logic       in_ready_q;
    logic       ld_q;
    logic       it_en_q;
    logic [4:0] shift_q;
    logic [4:0] lut_q;
    logic       fin_q;
    logic       out_valid_q;
    logic [8:0] out_exp_q;
    logic       out_err_q;

    logic       repeat_d;
    logic       last_d;
    logic [4:0] k_d;

    // Iteration schedule decision for the current k.
    always_comb begin
        repeat_d = 1'b0;
        last_d   = 1'b0;
        k_d      = k_q + 5'd1;
        if (((k_q == 5'd4) || (k_q == 5'd13)) && (k_q <= ITER_K) && !rep_q) begin
            repeat_d = 1'b1;
        end else if (k_q == ITER_K) begin
            last_d = 1'b1;
        end else begin
            repeat_d = 1'b0;
        end
    end

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= 5'd0;
            rep_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            ld_q        <= 1'b0;
            it_en_q     <= 1'b0;
            shift_q     <= 5'd0;
            lut_q       <= 5'd0;
            fin_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_exp_q   <= 9'd0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        out_exp_q  <= unbias(bus.in_exponent);
                        in_ready_q <= 1'b0;
                        if (is_reserved(bus.in_exponent)) begin
                            // Rejected operand skips the datapath entirely.
                            out_err_q   <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            out_err_q <= 1'b0;
                            ld_q      <= 1'b1;
                            state_q   <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    ld_q    <= 1'b0;
                    k_q     <= 5'd1;
                    rep_q   <= 1'b0;
                    it_en_q <= 1'b1;
                    shift_q <= 5'd1;
                    lut_q   <= 5'd0;
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    if (repeat_d) begin
                        // Same k again; shift/lut registers already hold it.
                        rep_q <= 1'b1;
                    end else if (last_d) begin
                        it_en_q <= 1'b0;
                        shift_q <= 5'd0;
                        lut_q   <= 5'd0;
                        fin_q   <= 1'b1;
                        state_q <= S_FIN;
                    end else begin
                        rep_q   <= 1'b0;
                        k_q     <= k_d;
                        shift_q <= k_d;
                        lut_q   <= k_q;
                    end
                end
                S_FIN: begin
                    fin_q       <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    k_q         <= 5'd0;
                    rep_q       <= 1'b0;
                    in_ready_q  <= 1'b1;
                    ld_q        <= 1'b0;
                    it_en_q     <= 1'b0;
                    shift_q     <= 5'd0;
                    lut_q       <= 5'd0;
                    fin_q       <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    // Operands offered while busy are discarded, never queued.
    assign bus.in_drop   = bus.in_valid & ~in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_exp   = out_exp_q;
    assign bus.out_err   = out_err_q;
    assign ld_o          = ld_q;
    assign it_en_o       = it_en_q;
    assign shift_o       = shift_q;
    assign lut_addr_o    = lut_q;
    assign fin_o         = fin_q;

endmodule

// File: tb/tb_cordic_log_seq.sv
`timescale 1ns/1ps
// Self-checking bench for cordic_log_seq: an ITER=16 instance (A) and an
// ITER=8 instance (B) share the same stimulus; sel picks which one is checked.
module tb_cordic_log_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_exponent;
    logic       out_ready;
    logic       sel;

    int n_vec;
    int n_miss;

    cordic_log_seq_if ifa ();
    cordic_log_seq_if ifb ();

    assign ifa.in_valid    = in_valid;
    assign ifa.in_exponent = in_exponent;
    assign ifa.out_ready   = out_ready;
    assign ifb.in_valid    = in_valid;
    assign ifb.in_exponent = in_exponent;
    assign ifb.out_ready   = out_ready;

    logic       ld_a, it_a, fin_a, ld_b, it_b, fin_b;
    logic [4:0] sh_a, lut_a, sh_b, lut_b;

    cordic_log_seq #(.ITER(16)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa),
        .ld_o(ld_a), .it_en_o(it_a), .shift_o(sh_a), .lut_addr_o(lut_a), .fin_o(fin_a)
    );

    cordic_log_seq #(.ITER(8)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb),
        .ld_o(ld_b), .it_en_o(it_b), .shift_o(sh_b), .lut_addr_o(lut_b), .fin_o(fin_b)
    );

    wire       c_ld    = sel ? ld_b  : ld_a;
    wire       c_it    = sel ? it_b  : it_a;
    wire       c_fin   = sel ? fin_b : fin_a;
    wire [4:0] c_sh    = sel ? sh_b  : sh_a;
    wire [4:0] c_lut   = sel ? lut_b : lut_a;
    wire       c_rdy   = sel ? ifb.in_ready  : ifa.in_ready;
    wire       c_drop  = sel ? ifb.in_drop   : ifa.in_drop;
    wire       c_ov    = sel ? ifb.out_valid : ifa.out_valid;
    wire [8:0] c_oe    = sel ? ifb.out_exp   : ifa.out_exp;
    wire       c_err   = sel ? ifb.out_err   : ifa.out_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] e;
        logic [8:0] oe;
        logic       err;
        int         t;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One transaction from handshake to result acceptance, checked cycle by cycle.
    // rdy_cyc < 0 : out_ready always high; otherwise high from that cycle on.
    // drop_cyc    : cycle in which a stray in_valid is offered (0 = none).
    task automatic run_txn(input string tag, input logic [7:0] e, input int t,
                           input logic [8:0] exp_oe, input logic exp_err,
                           input int rdy_cyc, input int drop_cyc, input int itr);
        int exp_sh[$];
        int got_sh[$];
        int ld_n, ld_c, fin_n, fin_c, ov_c, busy_bad, ov_gap, lut_bad, sh_bad;
        logic [8:0] oe;
        logic er;
        bit done;
        if (!exp_err) begin
            for (int k = 1; k <= itr; k++) begin
                exp_sh.push_back(k);
                if (k == 4 || k == 13) exp_sh.push_back(k);
            end
        end
        ld_n = 0; ld_c = -1; fin_n = 0; fin_c = -1; ov_c = -1;
        busy_bad = 0; ov_gap = 0; lut_bad = 0; sh_bad = 0;
        oe = 9'd0; er = 1'b0; done = 1'b0;
        chk({tag, "_ready_before"}, int'(c_rdy), 1);
        in_exponent = e;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            out_ready = (rdy_cyc < 0) || (c >= rdy_cyc);
            in_valid  = (c == drop_cyc);
            @(negedge clk);
            if (c == drop_cyc) chk({tag, "_in_drop"}, int'(c_drop), 1);
            if (c_rdy) busy_bad++;
            if (c_ld) begin ld_n++; if (ld_c < 0) ld_c = c; end
            if (c_fin) begin fin_n++; if (fin_c < 0) fin_c = c; end
            if (c_it) begin
                got_sh.push_back(int'(c_sh));
                if (int'(c_lut) != int'(c_sh) - 1) lut_bad++;
            end else if (c_sh != 5'd0 || c_lut != 5'd0) begin
                sh_bad++;
            end
            if (c_ov) begin
                if (ov_c < 0) begin ov_c = c; oe = c_oe; er = c_err; end
                else if (c_oe != oe || c_err != er) ov_gap++;
            end else if (ov_c >= 0) begin
                ov_gap++;
            end
            if (c_ov && out_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_completed"}, int'(done), 1);
        chk({tag, "_ld_count"}, ld_n, exp_err ? 0 : 1);
        if (!exp_err) chk({tag, "_ld_cycle"}, ld_c, 1);
        chk({tag, "_it_count"}, got_sh.size(), t);
        for (int i = 0; i < got_sh.size() && i < exp_sh.size(); i++)
            if (got_sh[i] != exp_sh[i]) sh_bad++;
        chk({tag, "_shift_seq_bad"}, sh_bad + lut_bad, 0);
        chk({tag, "_fin_count"}, fin_n, exp_err ? 0 : 1);
        if (!exp_err) chk({tag, "_fin_cycle"}, fin_c, t + 2);
        chk({tag, "_ov_cycle"}, ov_c, exp_err ? 1 : t + 3);
        chk({tag, "_ov_hold_bad"}, ov_gap, 0);
        chk({tag, "_busy_ready"}, busy_bad, 0);
        chk({tag, "_out_exp"}, int'(oe), int'(exp_oe));
        chk({tag, "_out_err"}, int'(er), int'(exp_err));
        @(negedge clk);
        chk({tag, "_ready_after"}, int'(c_rdy), 1);
        chk({tag, "_ov_after"}, int'(c_ov), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit found;
        int cyc;
        n_vec = 0; n_miss = 0;
        sel = 1'b0;
        in_valid = 1'b0; in_exponent = 8'h00; out_ready = 1'b0;

        vecs[0] = '{e: 8'h80, oe: 9'h001, err: 1'b0, t: 18};
        vecs[1] = '{e: 8'hFF, oe: 9'h080, err: 1'b1, t: 0};
        vecs[2] = '{e: 8'h00, oe: 9'h181, err: 1'b1, t: 0};
        vecs[3] = '{e: 8'h01, oe: 9'h182, err: 1'b0, t: 18};
        vecs[4] = '{e: 8'hFE, oe: 9'h07F, err: 1'b0, t: 18};
        vecs[5] = '{e: 8'h7F, oe: 9'h000, err: 1'b0, t: 18};

        // Reset state
        reset = 1'b1;
        #12;
        chk("rst_in_ready", int'(c_rdy), 1);
        chk("rst_outputs", int'({c_ld, c_it, c_fin, c_ov, c_err, c_sh, c_lut, c_oe}), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Table-driven transactions, out_ready always high
        for (int i = 0; i < 6; i++)
            run_txn($sformatf("vec%0d", i), vecs[i].e, vecs[i].t, vecs[i].oe, vecs[i].err, -1, 0, 16);

        // Result held until out_ready in cycle 26, stray in_valid in cycle 10
        run_txn("hold", 8'h80, 18, 9'h001, 1'b0, 26, 10, 16);

        // Reset while iterating at shift 7
        in_exponent = 8'h80; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (c_it && c_sh == 5'd7) found = 1'b1;
        end
        chk("midrst_reach_shift7", int'(found), 1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_in_ready", int'(c_rdy), 1);
        chk("midrst_outputs", int'({c_ld, c_it, c_fin, c_ov, c_err, c_sh, c_lut, c_oe}), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        run_txn("after_rst", 8'h7F, 18, 9'h000, 1'b0, -1, 0, 16);

        // out_ready and in_valid together in DONE: drop, then accept in IDLE
        in_exponent = 8'h80; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (c_ov) found = 1'b1;
        end
        chk("done_reached", int'(found), 1);
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_exponent = 8'h81;
        @(negedge clk);
        chk("done_in_drop", int'(c_drop), 1);
        chk("done_in_ready", int'(c_rdy), 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", int'(c_rdy), 1);
        chk("idle_in_drop", int'(c_drop), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("next_ld_cycle1", int'(c_ld), 1);
        found = 1'b0;
        cyc = 1;
        for (int c = 2; c < 40 && !found; c++) begin
            @(negedge clk);
            if (c_ov) begin found = 1'b1; cyc = c; end
        end
        chk("next_ov_cycle", cyc, 21);
        chk("next_out_exp", int'(c_oe), 2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // ITER = 8 instance
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        sel = 1'b1;
        run_txn("iter8", 8'h01, 9, 9'h182, 1'b0, -1, 0, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
